row_map_loader: RTL

- Write-side controller for the 9-bit x 512-entry row remap table in the readout path.
- Sequences host remap writes and a built-in identity-map initialisation into the table's addr/data/write-enable port.
- Spaces write pulses so the table's internal multi-cycle write sequence is never overrun.
- Blocks all writes while a frame scan is reading the table.

---
 rtl/row_map_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/row_map_loader.sv
// row_map_loader: write-side sequencer for the row remap table (host writes + identity init, gap-spaced pulses, scan lockout)
//   in : clk, rst (async, active high), init_start, wr_valid, wr_addr, wr_data, scan_active
//   out: wr_ready, mem_write_addr, mem_write_data, mem_write_en, busy, init_done, write_count
module row_map_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9,
  parameter int DEPTH  = 512,
  parameter int WE_GAP = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              scan_active,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              busy,
  output logic              init_done,
  output logic [15:0]       write_count
);
  localparam int GW = $clog2(WE_GAP + 1);
  typedef enum logic [2:0] {IDLE, HOST_PULSE, INIT_WAIT, INIT_PULSE, GAP} state_t;
  state_t r_state, w_state;
  logic [ADDR_W-1:0] r_idx, w_idx, r_addr, w_addr;
  logic [DATA_W-1:0] r_data, w_data;
  logic [GW-1:0] r_gap;
  logic [15:0] r_cnt;
  logic r_init, w_init, r_done, w_done, w_gap_end, w_accept, w_last;
  assign w_gap_end = r_state == GAP && r_gap == GW'(WE_GAP - 1);
  assign wr_ready = (r_state == IDLE || (w_gap_end && !r_init)) && !scan_active && !init_start;
  assign w_accept = wr_valid && wr_ready;
  assign w_last = r_idx == ADDR_W'(DEPTH - 1);
  assign mem_write_en = r_state == HOST_PULSE || r_state == INIT_PULSE;
  assign mem_write_addr = r_addr;
  assign mem_write_data = r_data;
  assign busy = r_state != IDLE;
  assign init_done = r_done;
  assign write_count = r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state;
  // The init pulse decision looks at this cycle's scan_active, so a pulse
  // only ever issues in the cycle after scan_active was seen low.
  always_comb begin
    w_state = r_state;
    w_idx = r_idx;
    w_addr = r_addr;
    w_data = r_data;
    w_init = r_init;
    w_done = 1'b0;
    case (r_state)
      IDLE:
        if (init_start) begin
          w_state = INIT_WAIT;
          w_init = 1'b1;
          w_idx = '0;
        end else if (w_accept) begin
          w_state = HOST_PULSE;
          w_addr = wr_addr;
          w_data = wr_data;
        end
      HOST_PULSE, INIT_PULSE: w_state = GAP;
      INIT_WAIT:
        if (!scan_active) begin
          w_state = INIT_PULSE;
          w_addr = r_idx;
          w_data = DATA_W'(r_idx);
        end
      GAP:
        if (w_gap_end) begin
          if (r_init && w_last) begin
            w_state = IDLE;
            w_init = 1'b0;
            w_idx = '0;
            w_done = 1'b1;
          end else if (r_init) begin
            w_idx = r_idx + 1'b1;
            w_state = scan_active ? INIT_WAIT : INIT_PULSE;
            w_addr = scan_active ? r_addr : r_idx + 1'b1;
            w_data = scan_active ? r_data : DATA_W'(r_idx + 1'b1);
          end else if (w_accept) begin
            w_state = HOST_PULSE;
            w_addr = wr_addr;
            w_data = wr_data;
          end else w_state = IDLE;
        end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_init <= 1'b0;
      r_done <= 1'b0;
      r_gap <= '0;
      r_cnt <= '0;
    end else begin
      r_idx <= w_idx;
      r_addr <= w_addr;
      r_data <= w_data;
      r_init <= w_init;
      r_done <= w_done;
      r_gap <= (r_state == GAP && !w_gap_end) ? r_gap + 1'b1 : '0;
      r_cnt <= mem_write_en ? r_cnt + 16'd1 : r_cnt;
    end
endmodule
